// File: rtl/booth_r4_seq_mult_if.sv
// Handshake and operand/result bundle for the sequential radix-4 Booth multiplier.
// The controller uses the master modport and the multiplier uses the slave modport.
interface booth_r4_seq_mult_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   y;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, y
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, y
    );
endinterface

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier that retires two multiplier bits per clock.
// It supports signed and unsigned operands and uses a start/busy/done handshake.
module booth_r4_seq_mult #(
    parameter int WIDTH = 8,
    parameter int ITER  = (WIDTH + 2) / 2
) (
    input  logic                    clk,
    input  logic                    rst,
    booth_r4_seq_mult_if.slave      bus
);
    localparam int XW = WIDTH + 2;          // extended operand width
    localparam int HW = WIDTH + 5;          // accumulator (upper) half, headroom for +-2M sums
    localparam int QW = WIDTH + 3;          // multiplier half, including the b[-1] slot
    localparam int PW = HW + QW;            // combined shift register, >= 2*WIDTH+4
    localparam int CW = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [XW-1:0]      m_r;
    logic [PW-1:0]      p_r;
    logic [CW-1:0]      cnt_r;
    logic               busy_r;
    logic               done_r;
    logic [2*WIDTH-1:0] y_r;

    logic               load_s;
    logic               last_s;
    logic [XW-1:0]      a_ext_s;
    logic [XW-1:0]      b_ext_s;
    logic [HW-1:0]      mx_s;
    logic [HW-1:0]      pp_s;
    logic [HW-1:0]      sum_s;
    logic [PW-1:0]      p_nx_s;

    // Operand extension to WIDTH+2 bits: sign-extend in signed mode, zero-extend otherwise.
    always_comb begin
        a_ext_s = {2'b00, bus.a};
        b_ext_s = {2'b00, bus.b};
        if (bus.signed_mode) begin
            a_ext_s = {{2{bus.a[WIDTH-1]}}, bus.a};
            b_ext_s = {{2{bus.b[WIDTH-1]}}, bus.b};
        end else begin
            a_ext_s = {2'b00, bus.a};
            b_ext_s = {2'b00, bus.b};
        end
    end

    // Booth triplet selection, accumulation, and arithmetic shift right by two.
    always_comb begin
        mx_s = {{(HW-XW){m_r[XW-1]}}, m_r};
        pp_s = {HW{1'b0}};
        case (p_r[2:0])
            3'b000, 3'b111: pp_s = {HW{1'b0}};
            3'b001, 3'b010: pp_s = mx_s;
            3'b011:         pp_s = mx_s << 1;
            3'b100:         pp_s = -(mx_s << 1);
            3'b101, 3'b110: pp_s = -mx_s;
            default:        pp_s = {HW{1'b0}};
        endcase
        sum_s  = p_r[PW-1 -: HW] + pp_s;
        p_nx_s = $signed({sum_s, p_r[QW-1:0]}) >>> 2;
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        last_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    load_s     = 1'b1;
                    state_nx_s = CALC;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == LAST_CNT) begin
                    last_s     = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = CALC;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath and registered handshake outputs.
    // The final shifted register holds product*2, with one leftover multiplier bit in bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_r    <= {XW{1'b0}};
            p_r    <= {PW{1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            y_r    <= {(2*WIDTH){1'b0}};
        end else if (load_s) begin
            m_r    <= a_ext_s;
            p_r    <= {{HW{1'b0}}, b_ext_s, 1'b0};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (state_r == CALC) begin
            p_r    <= p_nx_s;
            cnt_r  <= cnt_r + CW'(1);
            busy_r <= ~last_s;
            done_r <= last_s;
            if (last_s) begin
                y_r <= p_nx_s[2*WIDTH:1];
            end
        end else begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.y    = y_r;
endmodule
